ram_wr_queue_2w1r: RTL and testbench
====================================

# ram_wr_queue_2w1r

Write-side front end for a single-write-port synchronous RAM. Accepts up to two register writebacks per cycle, buffers them in order in a small queue, and drains one entry per cycle into the RAM write port. Also supplies read data for two synchronous RAM read ports, forwarding values that are still queued so readers never see stale data. Sits between the writeback stage and a 2-read/1-write register-file RAM.

## Interface
- ADDR_W, default 5, width of the RAM address.
- DATA_W, default 32, width of the RAM data.
- DEPTH, default 4, number of queue entries; power of two, at least 2.

- clk  in  1  clock; every register updates on the rising edge.
- reset_x  in  1  asynchronous active-low reset.
- in_we1  in  1  write request 1; older than request 2 in the same cycle.
- in_waddr1  in  ADDR_W  address for request 1.
- in_wdata1  in  DATA_W  data for request 1.
- in_we2  in  1  write request 2.
- in_waddr2  in  ADDR_W  address for request 2.
- in_wdata2  in  DATA_W  data for request 2.
- in_ready  out  1  high when at least 2 entries are free.
- ram_we  out  1  RAM write enable.
- ram_waddr  out  ADDR_W  RAM write address.
- ram_wdata  out  DATA_W  RAM write data.
- raddr1  in  ADDR_W  read address 1; the same value is driven to the RAM.
- raddr2  in  ADDR_W  read address 2.
- ram_rdata1  in  DATA_W  RAM read data 1, valid one cycle after raddr1.
- ram_rdata2  in  DATA_W  RAM read data 2, valid one cycle after raddr2.
- rdata1  out  DATA_W  corrected read data 1.
- rdata2  out  DATA_W  corrected read data 2.
- count  out  clog2(DEPTH)+1  number of occupied entries.
- overflow  out  1  sticky flag: a write was dropped.

## Operation
- **Queue:** circular buffer with head and tail pointers and an occupancy counter.
- **Enqueue at an edge:** occurs only when in_ready is high.
  - Request 1 goes to the tail.
  - Request 2 goes to the next slot.
  - If only request 2 is active, it takes the tail slot.
- **Drop:** any write request while in_ready is low is dropped and sets overflow. overflow clears only on reset.
- **Drain:**
  - ram_we = (count != 0).
  - ram_waddr and ram_wdata are taken from the head entry, combinationally from the registers.
  - The head pops on every edge where ram_we is high.
- **Same-edge pop and push:** allowed. count_next = count − pop + pushes. Pointers wrap modulo DEPTH.
- **Same address in both requests:** both are enqueued. Request 2 is written last, so it wins in the RAM.
- **Forwarding lookup, at a read-sampling edge t:**
  - Searches every entry valid at cycle t, including the head being drained, for a match with raddrN.
  - The youngest match is registered as hitN and fwd_dataN.
  - At cycle t+1: rdataN = hitN ? fwd_dataN : ram_rdataN.
- **Writes accepted at edge t:** not visible to reads sampled at t. This matches RAM read-before-write behaviour. They are visible from the next sample onward.
- **Reset:**
  - Pointers and count are 0.
  - ram_we, ram_waddr, ram_wdata are 0.
  - hit1, hit2, fwd_data1, fwd_data2 are 0, so rdataN follows ram_rdataN.
  - overflow is 0 and in_ready is 1.
- **Reset mid-operation:** discards all queued writes; none reach the RAM.

## Timing
- A write accepted at edge t is presented on ram_we no earlier than cycle t+1 (after edge t).
- With an empty queue, RAM update latency is 2 edges from the request.
- Queue-to-RAM order is strictly FIFO, and at most one RAM write occurs per cycle.
- Sustained rate:
  - One request per cycle never fills the queue.
  - Two requests per cycle fill DEPTH−1 entries. in_ready then drops, and rises once count ≤ DEPTH−2.
- rdataN has 1-cycle latency from raddrN, the same as the RAM.
- The forward select is registered; the final mux is combinational on ram_rdataN.
- in_ready and count are registered-state functions with no combinational path from inputs.

## Configuration
- **RAM_WQ_FWD_EN defined:** forwarding logic is present as described.
- **RAM_WQ_FWD_EN undefined:**
  - No lookup or hit registers.
  - rdataN = ram_rdataN, a direct wire.
  - Readers may see stale data while writes are queued. The caller must then stall reads until count == 0.

## Test plan
- **Single write:** reset, then one write addr 3 = 0xA5A5_0001 at edge 0.
  - ram_we=1, addr 3, data 0xA5A5_0001 in cycle 1.
  - count back to 0 after edge 1.
- **Dual writes, same address:** 5 = 0x11 on port 1 and 5 = 0x22 on port 2, same cycle.
  - Two consecutive RAM writes, 0x11 then 0x22.
  - Reading addr 5 after both drain returns 0x22.
- **Fill and overflow:** dual writes every cycle with DEPTH=4.
  - in_ready falls when count reaches 3.
  - A further request while in_ready is low is dropped and overflow=1.
  - Only accepted writes appear on ram_we, in order.
- **Forwarding:** queue 7 = 0xDEAD, then read raddr1=7 while it is still queued and ram_rdata1=0.
  - rdata1=0xDEAD one cycle later.
  - Same test with RAM_WQ_FWD_EN undefined: rdata1=0.
- **Youngest match:** two queued writes to addr 9 (0x1 then 0x2), read addr 9 → rdata=0x2.
- **Reset mid-operation:** assert reset_x low with 3 entries queued.
  - ram_we=0 immediately (asynchronously), count=0, overflow=0.
  - No stale writes after reset is released.

Source files
------------

// File: rtl/ram_wr_queue_2w1r.sv
// ram_wr_queue_2w1r: write-side front end for a 2-read/1-write register-file RAM.
// Accepts up to two writebacks per cycle into a small in-order queue and drains
// one entry per cycle into the RAM write port.
// Optional macro RAM_WQ_FWD_EN: forwards still-queued write data to the two
// read ports so readers never observe stale RAM contents.
module ram_wr_queue_2w1r #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset_x,
  input  logic                    in_we1,
  input  logic [ADDR_W-1:0]       in_waddr1,
  input  logic [DATA_W-1:0]       in_wdata1,
  input  logic                    in_we2,
  input  logic [ADDR_W-1:0]       in_waddr2,
  input  logic [DATA_W-1:0]       in_wdata2,
  output logic                    in_ready,
  output logic                    ram_we,
  output logic [ADDR_W-1:0]       ram_waddr,
  output logic [DATA_W-1:0]       ram_wdata,
  input  logic [ADDR_W-1:0]       raddr1,
  input  logic [ADDR_W-1:0]       raddr2,
  input  logic [DATA_W-1:0]       ram_rdata1,
  input  logic [DATA_W-1:0]       ram_rdata2,
  output logic [DATA_W-1:0]       rdata1,
  output logic [DATA_W-1:0]       rdata2,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

  logic [ADDR_W-1:0] addr_mem_r [DEPTH];
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;
  logic              overflow_r;

  logic              ready_s;
  logic              pop_s;
  logic              push1_s;
  logic              push2_s;
  logic [PTR_W-1:0]  slot2_s;
  logic [CNT_W-1:0]  npush_s;

  // Two free slots are always reserved so a dual request can never overrun.
  assign ready_s = (count_r <= READY_MAX);
  assign pop_s   = (count_r != {CNT_W{1'b0}});
  assign push1_s = in_we1 & ready_s;
  assign push2_s = in_we2 & ready_s;
  // Request 2 takes the tail slot when request 1 is idle, else the slot after it.
  assign slot2_s = in_we1 ? (tail_r + PTR_W'(1'b1)) : tail_r;
  assign npush_s = CNT_W'(push1_s) + CNT_W'(push2_s);

  // Queue pointers, occupancy and the sticky dropped-write flag.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      head_r     <= {PTR_W{1'b0}};
      tail_r     <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (pop_s) begin
        head_r <= head_r + PTR_W'(1'b1);
      end
      tail_r  <= tail_r + PTR_W'(npush_s);
      count_r <= count_r - CNT_W'(pop_s) + npush_s;
      if ((in_we1 | in_we2) & ~ready_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Entry storage; contents only matter while counted as occupied, so no reset.
  always_ff @(posedge clk) begin
    if (push1_s) begin
      addr_mem_r[tail_r] <= in_waddr1;
      data_mem_r[tail_r] <= in_wdata1;
    end
    if (push2_s) begin
      addr_mem_r[slot2_s] <= in_waddr2;
      data_mem_r[slot2_s] <= in_wdata2;
    end
  end

  // Head entry drives the RAM write port; address/data are zero when idle.
  assign ram_we    = pop_s;
  assign ram_waddr = pop_s ? addr_mem_r[head_r] : {ADDR_W{1'b0}};
  assign ram_wdata = pop_s ? data_mem_r[head_r] : {DATA_W{1'b0}};
  assign in_ready  = ready_s;
  assign count     = count_r;
  assign overflow  = overflow_r;

`ifdef RAM_WQ_FWD_EN
  logic              hit1_s;
  logic              hit2_s;
  logic              match1_s;
  logic              match2_s;
  logic [PTR_W-1:0]  idx_s;
  logic [DATA_W-1:0] fwd1_s;
  logic [DATA_W-1:0] fwd2_s;
  logic              hit1_r;
  logic              hit2_r;
  logic [DATA_W-1:0] fwd1_r;
  logic [DATA_W-1:0] fwd2_r;

  // Youngest-match lookup: walk occupied entries oldest to youngest, later matches override.
  always_comb begin
    hit1_s   = 1'b0;
    hit2_s   = 1'b0;
    match1_s = 1'b0;
    match2_s = 1'b0;
    fwd1_s   = {DATA_W{1'b0}};
    fwd2_s   = {DATA_W{1'b0}};
    idx_s    = head_r;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s    = head_r + PTR_W'(i);
      match1_s = (CNT_W'(i) < count_r) && (addr_mem_r[idx_s] == raddr1);
      match2_s = (CNT_W'(i) < count_r) && (addr_mem_r[idx_s] == raddr2);
      hit1_s   = hit1_s | match1_s;
      hit2_s   = hit2_s | match2_s;
      fwd1_s   = match1_s ? data_mem_r[idx_s] : fwd1_s;
      fwd2_s   = match2_s ? data_mem_r[idx_s] : fwd2_s;
    end
  end

  // Register the forward select alongside the RAM's own read sampling.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      hit1_r <= 1'b0;
      hit2_r <= 1'b0;
      fwd1_r <= {DATA_W{1'b0}};
      fwd2_r <= {DATA_W{1'b0}};
    end else begin
      hit1_r <= hit1_s;
      hit2_r <= hit2_s;
      fwd1_r <= fwd1_s;
      fwd2_r <= fwd2_s;
    end
  end

  assign rdata1 = hit1_r ? fwd1_r : ram_rdata1;
  assign rdata2 = hit2_r ? fwd2_r : ram_rdata2;
`else
  // Without forwarding the read addresses only go to the RAM itself.
  logic unused_raddr_s;
  assign unused_raddr_s = ^{raddr1, raddr2};
  assign rdata1 = ram_rdata1;
  assign rdata2 = ram_rdata2;
`endif

endmodule

// File: tb/tb_ram_wr_queue_2w1r.sv
// tb_ram_wr_queue_2w1r: directed scoreboard bench for ram_wr_queue_2w1r.
// Contains a behavioural read-before-write RAM on the DUT's RAM ports.
`timescale 1ns/1ps
module tb_ram_wr_queue_2w1r;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

`ifdef RAM_WQ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_x = 1'b1;
  logic              in_we1 = 1'b0;
  logic              in_we2 = 1'b0;
  logic [ADDR_W-1:0] in_waddr1 = '0;
  logic [ADDR_W-1:0] in_waddr2 = '0;
  logic [DATA_W-1:0] in_wdata1 = '0;
  logic [DATA_W-1:0] in_wdata2 = '0;
  logic              in_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [ADDR_W-1:0] raddr1 = '0;
  logic [ADDR_W-1:0] raddr2 = '0;
  logic [DATA_W-1:0] ram_rdata1 = '0;
  logic [DATA_W-1:0] ram_rdata2 = '0;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [2:0]        count;
  logic              overflow;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  logic [ADDR_W+DATA_W-1:0] wq  [$];
  logic [DATA_W-1:0]        rq1 [$];
  logic [DATA_W-1:0]        rq2 [$];
  logic [DATA_W-1:0]        ram_mem [32];

  int m_cnt = 0;
  bit m_ovf = 1'b0;
  bit re1 = 1'b0, re2 = 1'b0, rv1 = 1'b0, rv2 = 1'b0;
  wire m_rdy = (m_cnt <= DEPTH - 2);

  ram_wr_queue_2w1r #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_x(reset_x),
    .in_we1(in_we1), .in_waddr1(in_waddr1), .in_wdata1(in_wdata1),
    .in_we2(in_we2), .in_waddr2(in_waddr2), .in_wdata2(in_wdata2),
    .in_ready(in_ready),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .raddr1(raddr1), .raddr2(raddr2),
    .ram_rdata1(ram_rdata1), .ram_rdata2(ram_rdata2),
    .rdata1(rdata1), .rdata2(rdata2),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", nm, act, exp);
  endtask

  // Behavioural 2R1W RAM with read-before-write on a same-address collision.
  always @(posedge clk) begin
    ram_rdata1 <= ram_mem[raddr1];
    ram_rdata2 <= ram_mem[raddr2];
    if (ram_we) ram_mem[ram_waddr] <= ram_wdata;
  end

  // Reference occupancy model; accepted requests are pushed into the write scoreboard.
  always @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      m_cnt <= 0;
      m_ovf <= 1'b0;
      rv1   <= 1'b0;
      rv2   <= 1'b0;
      wq.delete();
    end else begin
      if (m_rdy && in_we1) wq.push_back({in_waddr1, in_wdata1});
      if (m_rdy && in_we2) wq.push_back({in_waddr2, in_wdata2});
      if (!m_rdy && (in_we1 || in_we2)) m_ovf <= 1'b1;
      m_cnt <= m_cnt - ((m_cnt != 0) ? 1 : 0)
               + ((m_rdy && in_we1) ? 1 : 0) + ((m_rdy && in_we2) ? 1 : 0);
      rv1 <= re1;
      rv2 <= re2;
    end
  end

  // Monitor: status, presented RAM writes and read data against the scoreboard.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, m_rdy);
      chk("count", count, m_cnt);
      chk("overflow", overflow, m_ovf);
      chk("ram_we", ram_we, m_cnt != 0);
      if (ram_we) begin
        chk("write_expected", wq.size() != 0, 1);
        if (wq.size() != 0) chk("ram_write", {ram_waddr, ram_wdata}, wq.pop_front());
      end
      if (rv1) begin
        chk("read1_expected", rq1.size() != 0, 1);
        if (rq1.size() != 0) chk("rdata1", rdata1, rq1.pop_front());
      end
      if (rv2) begin
        chk("read2_expected", rq2.size() != 0, 1);
        if (rq2.size() != 0) chk("rdata2", rdata2, rq2.pop_front());
      end
    end
  end

  // One clock of stimulus: optional writes on both ports and reads with expected data.
  task automatic cyc(input bit w1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                     input bit w2, input logic [ADDR_W-1:0] a2, input logic [DATA_W-1:0] d2,
                     input bit r1, input logic [ADDR_W-1:0] ra1, input logic [DATA_W-1:0] e1,
                     input bit r2, input logic [ADDR_W-1:0] ra2, input logic [DATA_W-1:0] e2);
    in_we1 = w1; in_waddr1 = a1; in_wdata1 = d1;
    in_we2 = w2; in_waddr2 = a2; in_wdata2 = d2;
    re1 = r1; raddr1 = ra1;
    re2 = r2; raddr2 = ra2;
    if (r1) rq1.push_back(e1);
    if (r2) rq2.push_back(e2);
    @(posedge clk); #1;
    in_we1 = 1'b0; in_we2 = 1'b0; re1 = 1'b0; re2 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ram_mem[i] = '0;
    #1 reset_x = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_waddr", ram_waddr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_rdata1", rdata1, 0);
    reset_x = 1'b1;
    chk_en  = 1'b1;

    // Single write: presented in the following cycle, queue empty one edge later.
    cyc(1, 5'd3, 32'hA5A5_0001, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("single_we", ram_we, 1);
    chk("single_waddr", ram_waddr, 3);
    chk("single_wdata", ram_wdata, 32'hA5A5_0001);
    chk("single_count", count, 1);
    idle(1);
    chk("single_count_after", count, 0);

    // Same address on both ports: port 2 lands last.
    cyc(1, 5'd5, 32'h11, 1, 5'd5, 32'h22, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("dual_count", count, 2);
    chk("dual_first_wdata", ram_wdata, 32'h11);
    idle(2);
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd5, 32'h22, 1, 5'd5, 32'h22);
    idle(1);

    // Forwarding from a queued entry that the RAM does not yet hold.
    cyc(1, 5'd7, 32'hDEAD, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd7, FWD ? 32'hDEAD : 32'h0, 0, 5'd0, 32'h0);
    idle(2);

    // Youngest match across cycles; a write accepted at the read edge is not visible.
    cyc(1, 5'd9, 32'h1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    cyc(1, 5'd9, 32'h2, 0, 5'd0, 32'h0, 1, 5'd9, FWD ? 32'h1 : 32'h0, 0, 5'd0, 32'h0);
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd9, FWD ? 32'h2 : 32'h1);
    idle(2);
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd9, 32'h2, 0, 5'd0, 32'h0);
    // Youngest match within one dual request.
    cyc(1, 5'd9, 32'h3, 1, 5'd9, 32'h4, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd9, FWD ? 32'h4 : 32'h2, 1, 5'd9, FWD ? 32'h4 : 32'h2);
    idle(3);
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd9, 32'h4, 0, 5'd0, 32'h0);
    idle(1);

    // Fill and overflow with dual requests every cycle.
    chk("fill_start_count", count, 0);
    cyc(1, 5'd10, 32'h100, 1, 5'd11, 32'h101, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("fill_ready_2", in_ready, 1);
    chk("fill_count_2", count, 2);
    cyc(1, 5'd12, 32'h102, 1, 5'd13, 32'h103, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("fill_ready_3", in_ready, 0);
    chk("fill_count_3", count, 3);
    chk("fill_no_ovf_yet", overflow, 0);
    cyc(1, 5'd14, 32'h104, 1, 5'd15, 32'h105, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("drop_overflow", overflow, 1);
    chk("drop_count", count, 2);
    chk("drop_ready", in_ready, 1);
    cyc(1, 5'd16, 32'h106, 1, 5'd17, 32'h107, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("refill_count", count, 3);

    // Asynchronous reset with three entries queued.
    reset_x = 1'b0;
    #1;
    chk("mid_rst_ram_we", ram_we, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    reset_x = 1'b1;
    idle(4);

    // Normal operation resumes after reset.
    cyc(1, 5'd20, 32'hCAFE, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    idle(3);
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd20, 32'hCAFE, 1, 5'd16, 32'h0);
    idle(2);

    chk("wq_drained", wq.size(), 0);
    chk("rq1_drained", rq1.size(), 0);
    chk("rq2_drained", rq2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
